// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter, LSB first, idle-high line, with peer
// flow control through an active-low clear-to-send input.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per bit time (min 2)
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   tx          serial line out, idle 1 (registered)
//   cts_n       peer ready, active low, asynchronous to clk
//   data        byte to send, sampled on accept
//   data_valid  producer has a byte, held until acknowledged
//   data_ack_n  active-low one-cycle accept pulse (registered)
//   busy        high from start bit through stop bit (registered)
//
// Optional build macro UART_TX_PARITY_EN inserts an even-parity bit
// between the last data bit and the stop bit (11 bit-times per frame).
module uart_tx #(
  parameter int CLKS_PER_BIT = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       tx,
  input  logic       cts_n,
  input  logic [7:0] data,
  input  logic       data_valid,
  output logic       data_ack_n,
  output logic       busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t           state;
  logic [7:0]       shift;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [1:0]       cts_sync;
  logic             cts_s;
`ifdef UART_TX_PARITY_EN
  logic             parity;
`endif

  // Synchroniser resets to "not ready" so nothing is sent until the
  // peer's ready has been seen through both flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cts_sync <= '1;
    else        cts_sync <= {cts_sync[0], cts_n};
  end

  assign cts_s = cts_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tx         <= 1'b1;
      data_ack_n <= 1'b1;
      busy       <= 1'b0;
      shift      <= '0;
      cnt        <= '0;
      idx        <= '0;
`ifdef UART_TX_PARITY_EN
      parity     <= 1'b0;
`endif
    end else begin
      data_ack_n <= 1'b1;
      case (state)
        IDLE: begin
          tx   <= 1'b1;
          busy <= 1'b0;
          if (data_valid && !cts_s) begin
            // tx/busy are registered here so the start bit appears in
            // the same cycle as the ack pulse.
            shift      <= data;
`ifdef UART_TX_PARITY_EN
            parity     <= ^data;
`endif
            data_ack_n <= 1'b0;
            cnt        <= RELOAD;
            idx        <= '0;
            tx         <= 1'b0;
            busy       <= 1'b1;
            state      <= START;
          end
        end

        START: begin
          if (cnt == '0) begin
            cnt   <= RELOAD;
            tx    <= shift[0];
            state <= DATA;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        DATA: begin
          if (cnt == '0) begin
            cnt   <= RELOAD;
            shift <= {1'b0, shift[7:1]};
            if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx    <= parity;
              state <= PARITY;
`else
              tx    <= 1'b1;
              state <= STOP;
`endif
            end else begin
              idx <= idx + 3'd1;
              tx  <= shift[1];
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (cnt == '0) begin
            cnt   <= RELOAD;
            tx    <= 1'b1;
            state <= STOP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`endif

        STOP: begin
          if (cnt == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

  localparam int C = 32;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int MAXW = 50;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx;
  logic       cts_n;
  logic [7:0] data;
  logic       data_valid;
  logic       data_ack_n;
  logic       busy;

  int tests = 0;
  int fails = 0;

  uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx         (tx),
    .cts_n      (cts_n),
    .data       (data),
    .data_valid (data_valid),
    .data_ack_n (data_ack_n),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic [9:0] frame;  // bit t = line value during bit-time t (start first)
    logic       par;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents d, waits for the ack, then checks every cycle of the frame.
  // Returns at the first cycle after the frame (line idle, busy low).
  task automatic run_frame(input logic [7:0] d, input logic [9:0] frame10, input logic par,
                           input bit keep_valid, input logic [7:0] next_d,
                           input int cts_rise_t, output int waited);
    logic [10:0] exp;
    int errs;
    int first_t;
    data = d;
    data_valid = 1'b1;
    waited = 0;
    do begin
      tick();
      waited++;
    end while (data_ack_n !== 1'b0 && waited < MAXW);
    if (data_ack_n !== 1'b0) begin
      check($sformatf("ack_timeout %h", d), {31'b0, data_ack_n}, 32'd0);
      data_valid = 1'b0;
      return;
    end
    check($sformatf("start_tx %h", d), {31'b0, tx}, 32'd0);
    check($sformatf("start_busy %h", d), {31'b0, busy}, 32'd1);
    if (keep_valid) data = next_d;
    else begin
      data_valid = 1'b0;
      data = ~d;
    end
`ifdef UART_TX_PARITY_EN
    exp = {1'b1, par, frame10[8:0]};
`else
    exp = {par & 1'b0, frame10};
`endif
    errs = 0;
    first_t = -1;
    for (int t = 0; t < NB * C; t++) begin
      if (t > 0) tick();
      if (t == cts_rise_t) cts_n = 1'b1;
      if (tx !== exp[t / C] || busy !== 1'b1 || (t > 0 && data_ack_n !== 1'b1)) begin
        if (errs == 0) first_t = t;
        errs++;
      end
    end
    check($sformatf("frame %h first bad t=%0d", d, first_t), errs, 32'd0);
    tick();
    check($sformatf("end_busy %h", d), {31'b0, busy}, 32'd0);
    check($sformatf("end_tx %h", d), {31'b0, tx}, 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int errs;
    vecs[0] = '{8'h55, 10'h2AA, 1'b0};
    vecs[1] = '{8'hA5, 10'h34A, 1'b0};
    vecs[2] = '{8'h3C, 10'h278, 1'b0};
    vecs[3] = '{8'h81, 10'h302, 1'b0};
    vecs[4] = '{8'h07, 10'h20E, 1'b1};
    vecs[5] = '{8'h03, 10'h206, 1'b0};
    vecs[6] = '{8'hFF, 10'h3FE, 1'b0};
    vecs[7] = '{8'h01, 10'h202, 1'b1};

    rst_n = 1'b0;
    cts_n = 1'b0;
    data = 8'h00;
    data_valid = 1'b0;
    repeat (3) tick();
    check("reset_tx", {31'b0, tx}, 32'd1);
    check("reset_ack", {31'b0, data_ack_n}, 32'd1);
    check("reset_busy", {31'b0, busy}, 32'd0);
    rst_n = 1'b1;
    repeat (4) tick();
    check("idle_tx", {31'b0, tx}, 32'd1);
    check("idle_busy", {31'b0, busy}, 32'd0);

    // Table of single frames, peer always ready.
    for (int i = 0; i < 8; i++) begin
      run_frame(vecs[i].d, vecs[i].frame, vecs[i].par, 1'b0, 8'h00, -1, w);
      check($sformatf("accept_latency %h", vecs[i].d), w, 32'd1);
      repeat (3) tick();
    end

    // Peer not ready: byte must wait, then go within 3 cycles of cts_n low.
    cts_n = 1'b1;
    repeat (3) tick();
    data = 8'hA5;
    data_valid = 1'b1;
    errs = 0;
    for (int t = 0; t < 1000; t++) begin
      tick();
      if (data_ack_n !== 1'b1 || tx !== 1'b1 || busy !== 1'b0) errs++;
    end
    check("cts_hold", errs, 32'd0);
    cts_n = 1'b0;
    run_frame(8'hA5, 10'h34A, 1'b0, 1'b1, 8'h3C, -1, w);
    check("cts_release_latency", w, 32'd3);
    // Back-to-back: 0x3C held valid from the ack cycle; accept on first IDLE cycle.
    run_frame(8'h3C, 10'h278, 1'b0, 1'b0, 8'h00, -1, w);
    check("b2b_gap", w, 32'd1);
    repeat (3) tick();

    // data_valid withdrawn before accept: nothing sent.
    cts_n = 1'b1;
    repeat (3) tick();
    data = 8'h99;
    data_valid = 1'b1;
    repeat (5) tick();
    data_valid = 1'b0;
    cts_n = 1'b0;
    errs = 0;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (data_ack_n !== 1'b1 || tx !== 1'b1 || busy !== 1'b0) errs++;
    end
    check("withdrawn_valid", errs, 32'd0);

    // Reset during data bit 3 of 0xFF.
    data = 8'hFF;
    data_valid = 1'b1;
    w = 0;
    do begin
      tick();
      w++;
    end while (data_ack_n !== 1'b0 && w < MAXW);
    check("rst_frame_ack", {31'b0, data_ack_n}, 32'd0);
    data_valid = 1'b0;
    repeat (4 * C + C / 2) tick();
    check("rst_frame_bit3", {31'b0, tx}, 32'd1);
    check("rst_frame_busy", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_tx", {31'b0, tx}, 32'd1);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_ack", {31'b0, data_ack_n}, 32'd1);
    tick();
    rst_n = 1'b1;
    errs = 0;
    for (int t = 0; t < 2 * C; t++) begin
      tick();
      if (data_ack_n !== 1'b1 || tx !== 1'b1 || busy !== 1'b0) errs++;
    end
    check("post_rst_idle", errs, 32'd0);
    run_frame(8'h81, 10'h302, 1'b0, 1'b0, 8'h00, -1, w);

    // Flow-controlled stream: peer drops ready mid-frame, frame completes,
    // next byte waits until ready returns.
    for (int i = 0; i < 8; i++) begin
      logic [7:0] b;
      b = 8'(8'h10 + i);
      run_frame(b, {1'b1, b, 1'b0}, ^b, 1'b0, 8'h00, 3 * C + 7 * i, w);
      check($sformatf("stream_latency %h", b), (w >= 1 && w <= 3) ? 32'd1 : 32'd0, 32'd1);
      data = 8'(b + 1);
      data_valid = 1'b1;
      errs = 0;
      for (int t = 0; t < 10 + 5 * i; t++) begin
        tick();
        if (data_ack_n !== 1'b1 || tx !== 1'b1 || busy !== 1'b0) errs++;
      end
      check($sformatf("stream_wait %h", b), errs, 32'd0);
      cts_n = 1'b0;
    end
    data_valid = 1'b0;
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
